// File: rtl/pong_pkg.sv
// pong_pkg: shared geometry, colour and FSM definitions for the Pong pixel stage
package pong_pkg;
  localparam int SCR_H = 480;
  localparam logic [9:0] WALL_L = 10'd32;
  localparam logic [9:0] WALL_R = 10'd35;
  localparam logic [9:0] PAD_L = 10'd600;
  localparam logic [9:0] PAD_R = 10'd603;
  localparam logic [9:0] MISS_X = 10'd636;
  localparam logic [9:0] BALL_X0 = 10'd316;
  localparam logic [9:0] BALL_Y0 = 10'd236;
  localparam logic [9:0] PAD_Y0 = 10'd204;
  localparam logic [2:0] COL_OFF = 3'b000;
  localparam logic [2:0] COL_WALL = 3'b001;
  localparam logic [2:0] COL_PAD = 3'b010;
  localparam logic [2:0] COL_BALL = 3'b100;
  localparam logic [2:0] COL_BG = 3'b110;
  typedef enum logic [1:0] {SERVE, PLAY, MISS} state_t;
endpackage

// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl: serve/play/miss FSM, ball position and direction, hit/miss pulses
module pong_ball_ctrl
  import pong_pkg::*;
#(
  parameter int BALL_SIZE = 8,
  parameter int BALL_V = 2,
  parameter int PAD_H = 72,
  parameter int MISS_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refr_tick,
  input  logic [9:0] pad_y,
  input  logic [1:0] btn,
  output logic [9:0] bx,
  output logic [9:0] by,
  output logic       ball_on_en,
  output logic       hit,
  output logic       miss
);
  localparam int CW = $clog2(MISS_FRAMES + 1);
  localparam logic [9:0] BS1 = 10'(BALL_SIZE - 1);
  localparam logic [9:0] BV = 10'(BALL_V);
  localparam logic [9:0] PH1 = 10'(PAD_H - 1);
  localparam logic [9:0] BOT = 10'(SCR_H - 1 - BALL_V);
  localparam logic [CW-1:0] CNT_END = CW'(MISS_FRAMES - 1);
  state_t state;
  logic dx, dy;
  logic [CW-1:0] cnt;
  logic [9:0] bx_r, by_b;
  logic top_hit, bot_hit, wall_hit, pad_hit, out;
  assign bx_r = bx + BS1;
  assign by_b = by + BS1;
  assign top_hit = by <= BV;
  assign bot_hit = by_b >= BOT;
  assign wall_hit = bx <= WALL_R + BV;
  assign pad_hit = dx && bx_r >= PAD_L && bx_r <= PAD_R && by <= pad_y + PH1 && by_b >= pad_y;
  assign out = bx_r >= MISS_X;
  assign ball_on_en = state != MISS;
  // dx: 1 = right, dy: 1 = down; movement uses the directions held before this tick
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= SERVE;
      bx <= BALL_X0;
      by <= BALL_Y0;
      dx <= 1'b0;
      dy <= 1'b1;
      cnt <= '0;
      hit <= 1'b0;
      miss <= 1'b0;
    end else begin
      hit <= refr_tick && state == PLAY && !out && pad_hit;
      miss <= refr_tick && state == PLAY && out;
      if (refr_tick)
        case (state)
          SERVE: if (btn != 2'b00) begin
            state <= PLAY;
            dx <= 1'b0;
            dy <= 1'b1;
          end
          PLAY: if (out) begin
            state <= MISS;
            cnt <= '0;
          end else begin
            bx <= dx ? bx + BV : bx - BV;
            by <= dy ? by + BV : by - BV;
            dy <= top_hit ? 1'b1 : bot_hit ? 1'b0 : dy;
            dx <= wall_hit ? 1'b1 : pad_hit ? 1'b0 : dx;
          end
          default: begin
            cnt <= cnt + CW'(1);
            if (cnt == CNT_END) begin
              state <= SERVE;
              bx <= BALL_X0;
              by <= BALL_Y0;
            end
          end
        endcase
    end
endmodule

// File: rtl/pong_graph.sv
// pong_graph: refresh tick, paddle, object colour mux and registered RGB output
module pong_graph
  import pong_pkg::*;
#(
  parameter int BALL_SIZE = 8,
  parameter int BALL_V = 2,
  parameter int PAD_H = 72,
  parameter int PAD_V = 4,
  parameter int MISS_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn,
  input  logic       video_on,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic [2:0] rgb,
  output logic       hit,
  output logic       miss
);
  localparam logic [9:0] PH = 10'(PAD_H);
  localparam logic [9:0] PH1 = 10'(PAD_H - 1);
  localparam logic [9:0] PV = 10'(PAD_V);
  localparam logic [9:0] BS1 = 10'(BALL_SIZE - 1);
  localparam logic [9:0] YMAX = 10'(SCR_H);
  logic y481, y481_d, refr_tick, ball_on_en;
  logic wall_on, pad_on, ball_on;
  logic [9:0] pad_y, bx, by;
  logic [2:0] rgb_next;
  assign refr_tick = y481 & ~y481_d;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      y481 <= 1'b0;
      y481_d <= 1'b0;
      pad_y <= PAD_Y0;
      rgb <= COL_OFF;
    end else begin
      y481 <= pixel_y == 10'd481;
      y481_d <= y481;
      rgb <= rgb_next;
      if (refr_tick)
        pad_y <= (btn == 2'b10 && pad_y + PH + PV <= YMAX) ? pad_y + PV :
                 (btn == 2'b01 && pad_y >= PV) ? pad_y - PV : pad_y;
    end
  assign wall_on = pixel_x >= WALL_L && pixel_x <= WALL_R;
  assign pad_on = pixel_x >= PAD_L && pixel_x <= PAD_R && pixel_y >= pad_y && pixel_y <= pad_y + PH1;
  assign ball_on = ball_on_en && pixel_x >= bx && pixel_x <= bx + BS1 && pixel_y >= by && pixel_y <= by + BS1;
  always_comb rgb_next = !video_on ? COL_OFF : wall_on ? COL_WALL : pad_on ? COL_PAD : ball_on ? COL_BALL : COL_BG;
  pong_ball_ctrl #(
    .BALL_SIZE(BALL_SIZE),
    .BALL_V(BALL_V),
    .PAD_H(PAD_H),
    .MISS_FRAMES(MISS_FRAMES)
  ) u_ball (
    .clk(clk),
    .reset(reset),
    .refr_tick(refr_tick),
    .pad_y(pad_y),
    .btn(btn),
    .bx(bx),
    .by(by),
    .ball_on_en(ball_on_en),
    .hit(hit),
    .miss(miss)
  );
endmodule
